// File: rtl/cplx_reg_bank_p_if.sv
// Bus bundle for the complex register bank: write port, two read ports,
// soft-clear request and busy flag. master = bank user, slave = bank.
interface cplx_reg_bank_p_if #(
    parameter int HW    = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic            clr;
    logic            busy;
    logic            regwen;
    logic [2*HW-1:0] inA;
    logic [AW-1:0]   selwreg;
    logic [1:0]      endwreg;
    logic [AW-1:0]   seloutA;
    logic [AW-1:0]   seloutB;
    logic            cnstA;
    logic            cnstB;
    logic            enrregA;
    logic            enrregB;
    logic [2*HW-1:0] outA;
    logic [2*HW-1:0] outB;
    logic            validA;
    logic            validB;

    modport master (
        output clr, regwen, inA, selwreg, endwreg,
        output seloutA, seloutB, cnstA, cnstB,
        output enrregA, enrregB,
        input  busy, outA, outB, validA, validB
    );

    modport slave (
        input  clr, regwen, inA, selwreg, endwreg,
        input  seloutA, seloutB, cnstA, cnstB,
        input  enrregA, enrregB,
        output busy, outA, outB, validA, validB
    );
endinterface

// File: rtl/cplx_reg_bank_p.sv
// Complex register bank: DEPTH entries of {real, imag}, HW bits each.
// Ports: clock, reset (sync, active-high), bus (cplx_reg_bank_p_if.slave):
//   write port (regwen/inA/selwreg/endwreg), read ports A/B
//   (selout/cnst/enrreg -> out/valid), soft clear (clr -> busy).
// Optional: define CPLX_REG_BANK_BYPASS_EN for read-during-write bypass.
module cplx_reg_bank_p #(
    parameter int HW    = 32,
    parameter int DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    cplx_reg_bank_p_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = 2 * HW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    logic [W-1:0]  bank [DEPTH];

    logic          clearing;
    logic          we;
    logic [W-1:0]  old_w;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          valid_a;
    logic          valid_b;

    function automatic logic [W-1:0] cnst_val(
        input logic [1:0] code
    );
        logic [HW-1:0] one;
        logic [HW-1:0] zero;
        logic [HW-1:0] neg;
        one      = HW'(1);
        zero     = '0;
        neg      = '1;
        cnst_val = '0;
        unique case (code)
            2'd0: cnst_val = {one, zero};
            2'd1: cnst_val = {neg, zero};
            2'd2: cnst_val = {zero, one};
            2'd3: cnst_val = {zero, neg};
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; clr is ignored while clearing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign clearing = (state_q == CLEAR);
    assign bus.busy = clearing;
    assign we       = bus.regwen && !clearing;

    // Partial writes merge with the retained half of the old entry
    assign old_w = bank[bus.selwreg];

    always_comb begin
        wdata = bus.inA;
        unique case (bus.endwreg)
            2'b00: wdata = bus.inA;
            2'b10: wdata = {bus.inA[W-1:HW], old_w[HW-1:0]};
            2'b01: wdata = {old_w[W-1:HW], bus.inA[HW-1:0]};
            2'b11: wdata = {bus.inA[HW-1:0], bus.inA[W-1:HW]};
        endcase
    end

    // Storage has no reset; a write coinciding with reset is lost
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clearing) begin
                bank[cnt_q] <= '0;
            end else if (we) begin
                bank[bus.selwreg] <= wdata;
            end
        end
    end

    always_comb begin
        rd_a = bank[bus.seloutA];
        rd_b = bank[bus.seloutB];
`ifdef CPLX_REG_BANK_BYPASS_EN
        // Return what the entry will hold after this edge
        if (clearing && bus.seloutA == cnt_q) begin
            rd_a = '0;
        end else if (we && bus.seloutA == bus.selwreg) begin
            rd_a = wdata;
        end
        if (clearing && bus.seloutB == cnt_q) begin
            rd_b = '0;
        end else if (we && bus.seloutB == bus.selwreg) begin
            rd_b = wdata;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_a   <= '0;
            out_b   <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            valid_a <= bus.enrregA;
            valid_b <= bus.enrregB;
            if (bus.enrregA) begin
                out_a <= bus.cnstA ? cnst_val(bus.seloutA[1:0]) : rd_a;
            end
            if (bus.enrregB) begin
                out_b <= bus.cnstB ? cnst_val(bus.seloutB[1:0]) : rd_b;
            end
        end
    end

    assign bus.outA   = out_a;
    assign bus.outB   = out_b;
    assign bus.validA = valid_a;
    assign bus.validB = valid_b;
endmodule

// File: tb/tb_cplx_reg_bank_p.sv
// Testbench for cplx_reg_bank_p: directed scenarios plus random traffic,
// checked by a queue-based scoreboard against an array reference model.
module tb_cplx_reg_bank_p;
    localparam int HW    = 32;
    localparam int DEPTH = 16;
    localparam int W     = 2 * HW;

    logic clock;
    logic reset;

    cplx_reg_bank_p_if #(.HW(HW), .DEPTH(DEPTH)) bus ();

    cplx_reg_bank_p #(.HW(HW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         busy;
        logic         va;
        logic         vb;
        logic [W-1:0] oa;
        logic [W-1:0] ob;
    } exp_t;

    exp_t sb_q[$];

    int passed = 0;
    int total  = 0;

    logic [W-1:0] m_bank [DEPTH];
    logic [W-1:0] m_oa;
    logic [W-1:0] m_ob;
    bit           m_va;
    bit           m_vb;
    bit           m_busy;
    int           m_cnt;

    logic [W-1:0] konst [4];

    function automatic void chk(string name, logic [W-1:0] act,
                                logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [W-1:0] merge(logic [W-1:0] old,
                                           logic [W-1:0] d,
                                           logic [1:0] mode);
        logic [HW-1:0] re;
        logic [HW-1:0] im;
        re = d[W-1:HW];
        im = d[HW-1:0];
        case (mode)
            2'b00:   return {re, im};
            2'b10:   return {re, old[HW-1:0]};
            2'b01:   return {old[W-1:HW], im};
            default: return {im, re};
        endcase
    endfunction

    // Reference model step for one rising edge, then advance the clock
    task automatic cycle();
        logic [W-1:0] nb [DEPTH];
        exp_t e;
        nb = m_bank;
        if (reset) begin
            m_oa   = '0;
            m_ob   = '0;
            m_va   = 0;
            m_vb   = 0;
            m_busy = 1;
            m_cnt  = 0;
        end else begin
            if (m_busy) nb[m_cnt] = '0;
            else if (bus.regwen)
                nb[bus.selwreg] = merge(m_bank[bus.selwreg],
                                        bus.inA, bus.endwreg);
            if (bus.enrregA) begin
                if (bus.cnstA) m_oa = konst[bus.seloutA[1:0]];
`ifdef CPLX_REG_BANK_BYPASS_EN
                else m_oa = nb[bus.seloutA];
`else
                else m_oa = m_bank[bus.seloutA];
`endif
            end
            if (bus.enrregB) begin
                if (bus.cnstB) m_ob = konst[bus.seloutB[1:0]];
`ifdef CPLX_REG_BANK_BYPASS_EN
                else m_ob = nb[bus.seloutB];
`else
                else m_ob = m_bank[bus.seloutB];
`endif
            end
            m_va = bus.enrregA;
            m_vb = bus.enrregB;
            if (m_busy) begin
                if (m_cnt == DEPTH - 1) m_busy = 0;
                m_cnt = (m_cnt + 1) % DEPTH;
            end else if (bus.clr) begin
                m_busy = 1;
                m_cnt  = 0;
            end
            m_bank = nb;
        end
        e.busy = m_busy;
        e.va   = m_va;
        e.vb   = m_vb;
        e.oa   = m_oa;
        e.ob   = m_ob;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle the DUT presents busy/valid/out; compare
    always @(negedge clock) begin : mon
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("busy", W'(bus.busy), W'(e.busy));
            chk("validA", W'(bus.validA), W'(e.va));
            chk("validB", W'(bus.validB), W'(e.vb));
            chk("outA", bus.outA, e.oa);
            chk("outB", bus.outB, e.ob);
        end
    end

    task automatic idle();
        bus.clr     = 0;
        bus.regwen  = 0;
        bus.enrregA = 0;
        bus.enrregB = 0;
        bus.cnstA   = 0;
        bus.cnstB   = 0;
    endtask

    task automatic do_write(int sel, logic [W-1:0] d, logic [1:0] m);
        bus.regwen  = 1;
        bus.selwreg = 4'(sel);
        bus.inA     = d;
        bus.endwreg = m;
        cycle();
        bus.regwen  = 0;
    endtask

    task automatic do_read_a(int sel);
        bus.enrregA = 1;
        bus.cnstA   = 0;
        bus.seloutA = 4'(sel);
        cycle();
        bus.enrregA = 0;
    endtask

    initial begin
        konst[0] = 64'h00000001_00000000;
        konst[1] = 64'hFFFFFFFF_00000000;
        konst[2] = 64'h00000000_00000001;
        konst[3] = 64'h00000000_FFFFFFFF;
        for (int i = 0; i < DEPTH; i++) m_bank[i] = 'x;
        m_oa = '0; m_ob = '0; m_va = 0; m_vb = 0;
        m_busy = 1; m_cnt = 0;

        reset       = 1;
        bus.inA     = '0;
        bus.selwreg = '0;
        bus.endwreg = '0;
        bus.seloutA = '0;
        bus.seloutB = '0;
        idle();
        cycle();
        cycle();
        chk("rst_outA", bus.outA, '0);
        chk("rst_outB", bus.outB, '0);
        chk("rst_busy", W'(bus.busy), W'(1));
        reset = 0;

        for (int i = 0; i < DEPTH - 1; i++) cycle();
        chk("init_busy_15", W'(bus.busy), W'(1));
        cycle();
        chk("init_busy_16", W'(bus.busy), W'(0));

        bus.enrregB = 1;
        bus.seloutB = 4'd12;
        do_read_a(5);
        bus.enrregB = 0;
        chk("init_r5", bus.outA, '0);
        chk("init_r12", bus.outB, '0);

        do_write(3, 64'h00000005_00000007, 2'b00);
        do_write(3, 64'h0000000A_FFFFFFFF, 2'b10);
        do_read_a(3);
        chk("r3_real_only", bus.outA, 64'h0000000A_00000007);

        do_write(9, 64'h11111111_22222222, 2'b11);
        do_read_a(9);
        chk("r9_swap", bus.outA, 64'h22222222_11111111);
        chk("r9_valid", W'(bus.validA), W'(1));
        cycle();
        chk("r9_valid_drop", W'(bus.validA), W'(0));

        bus.enrregA = 1; bus.cnstA = 1; bus.seloutA = 4'd1;
        bus.enrregB = 1; bus.cnstB = 1; bus.seloutB = 4'b1011;
        cycle();
        idle();
        chk("cnstA_m1", bus.outA, 64'hFFFFFFFF_00000000);
        chk("cnstB_mj", bus.outB, 64'h00000000_FFFFFFFF);

        do_write(2, 64'hCAFEF00D_12345678, 2'b00);
        bus.clr = 1;
        cycle();
        bus.clr = 0;
        cycle();
        cycle();
        do_write(2, 64'h0BAD0BAD_0BAD0BAD, 2'b00);
        for (int i = 0; i < 12; i++) begin
            bus.clr = (i == 3);
            cycle();
        end
        bus.clr = 0;
        chk("clr_busy_15", W'(bus.busy), W'(1));
        cycle();
        chk("clr_busy_16", W'(bus.busy), W'(0));
        do_read_a(2);
        chk("r2_dropped", bus.outA, '0);

        do_write(4, 64'hDEADBEEF_01234567, 2'b00);
        bus.enrregA = 1;
        bus.seloutA = 4'd4;
        do_write(4, 64'h00000001_00000002, 2'b00);
        bus.enrregA = 0;
`ifdef CPLX_REG_BANK_BYPASS_EN
        chk("r4_rdw", bus.outA, 64'h00000001_00000002);
`else
        chk("r4_rdw", bus.outA, 64'hDEADBEEF_01234567);
`endif

        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            bus.clr     = ($urandom_range(0, 39) == 0);
            bus.regwen  = $urandom_range(0, 1);
            bus.inA     = {$urandom, $urandom};
            bus.selwreg = 4'($urandom_range(0, DEPTH - 1));
            bus.endwreg = 2'($urandom_range(0, 3));
            bus.enrregA = $urandom_range(0, 1);
            bus.enrregB = $urandom_range(0, 1);
            bus.cnstA   = ($urandom_range(0, 3) == 0);
            bus.cnstB   = ($urandom_range(0, 3) == 0);
            bus.seloutA = ($urandom_range(0, 2) == 0) ?
                          bus.selwreg : 4'($urandom_range(0, DEPTH - 1));
            bus.seloutB = 4'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        reset = 0;
        idle();
        cycle();
        cycle();
        @(negedge clock);
        #1;
        chk("sb_drained", W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cplx_reg_bank_p.md
CPLX_REG_BANK_P -- requirements
Module: cplx_reg_bank_p

Interface
REQ-001 Parameter HW, default 32: half-word width; real part = high half, imaginary part = low half.
REQ-002 Parameter DEPTH, default 16: number of complex registers, power of two, >= 4.
REQ-003 Derived AW = clog2(DEPTH): address width; not overridable.
REQ-004 clock  input  1  master clock, posedge active.
REQ-005 reset  input  1  master reset, synchronous, active-high.
REQ-006 clr  input  1  soft-clear request; starts the clear sequence.
REQ-007 busy  output  1  high while the clear sequence runs.
REQ-008 regwen  input  1  write enable.
REQ-009 inA  input  2*HW  write data.
REQ-010 selwreg  input  AW  write register index.
REQ-011 endwreg  input  2  write mode.
REQ-012 seloutA, seloutB  input  AW  read index, or constant code when cnstX=1.
REQ-013 cnstA, cnstB  input  1  per port: 1 = load a constant, 0 = load from the bank.
REQ-014 enrregA, enrregB  input  1  per-port output-register load enable.
REQ-015 outA, outB  output  2*HW  registered read data.
REQ-016 validA, validB  output  1  high for the cycle after the matching output register loaded.

Function
REQ-017 The write mode decodes as follows:
- endwreg 00: write {inA_hi, inA_lo}.
- endwreg 10: write inA_hi to the real half only; the imaginary half is retained.
- endwreg 01: write inA_lo to the imaginary half only; the real half is retained.
- endwreg 11: write {inA_lo, inA_hi}, i.e. swapped halves.
REQ-018 A write SHALL take effect on the rising edge where regwen=1 and busy=0.
- Writes while busy=1 SHALL be dropped.
REQ-019 Ports A and B SHALL be fully independent. Both SHALL operate in the same cycle as a write and as each other.
REQ-020 When enrregX=1 and cnstX=0, outX SHALL load bank[seloutX] on that edge (1-cycle latency).
- validX SHALL be 1 in the following cycle.
REQ-021 When enrregX=1 and cnstX=1, outX SHALL load a constant selected by seloutX[1:0]. Each half is an HW-bit two's-complement value:
- 0: {1, 0}
- 1: {-1, 0}
- 2: {0, 1}
- 3: {0, -1}
- Upper seloutX bits are ignored.
REQ-022 When enrregX=0, outX SHALL hold its value and validX SHALL be 0 next cycle.
REQ-023 The FSM SHALL have two states, IDLE and CLEAR, with an AW-bit counter cnt.
REQ-024 IDLE -> CLEAR on clr=1. Entering CLEAR sets cnt=0.
REQ-025 In CLEAR, each cycle SHALL zero bank[cnt] and increment cnt.
- When cnt = DEPTH-1 the FSM SHALL return to IDLE on that edge.
- The sequence takes exactly DEPTH cycles.
REQ-026 busy SHALL be 1 exactly while in CLEAR.
- clr asserted during CLEAR SHALL be ignored; the sequence does not restart.
REQ-027 Reads during CLEAR SHALL be allowed.
- A read returns the current contents: zero for already-cleared entries, old data for the rest.
REQ-028 Without bypass, a read of the address written on the same edge SHALL return the pre-write value.

Reset
REQ-029 On reset the following SHALL be set:
- outA = 0, outB = 0
- validA = 0, validB = 0
- FSM = CLEAR, cnt = 0, busy = 1
REQ-030 The bank array itself SHALL have no reset. After reset the sequence zeroes it over DEPTH cycles, with busy falling on cycle DEPTH.
REQ-031 Reset asserted mid-clear SHALL restart the sequence from cnt=0.
- Reset asserted mid-write SHALL drop the write.

Configuration
REQ-032 Macro CPLX_REG_BANK_BYPASS_EN controls read-during-write bypass.
- Defined: a same-edge read of an address being written SHALL return the post-write merged value (including retained and swapped halves). An entry being cleared on that edge SHALL read 0.
- Undefined: REQ-028 applies.
- Constant reads are unaffected in both cases.

Verification
REQ-033 Reset -> busy=1 for 16 cycles (DEPTH=16), then 0. Reading any register afterwards returns 0.
REQ-034 Write 0x00000005_00000007 to r3 with endwreg=00, then endwreg=10 with inA=0x0000000A_FFFFFFFF -> reading r3 returns 0x0000000A_00000007.
REQ-035 Write 0x11111111_22222222 to r9 with endwreg=11 -> r9 reads 0x22222222_11111111. validA pulses exactly one cycle after enrregA.
REQ-036 cnstA=1 with seloutA=1, and cnstB=1 with seloutB=3, in the same cycle -> outA=0xFFFFFFFF_00000000, outB=0x00000000_FFFFFFFF.
REQ-037 Set clr=1, then regwen to r2 on the third busy cycle -> write dropped, r2=0 after the sequence ends. A second clr mid-sequence keeps the length at 16 cycles.
REQ-038 Write r4 = 0x1_2 and read r4 on port A in the same cycle -> outA returns the old value without the macro, and 0x00000001_00000002 with CPLX_REG_BANK_BYPASS_EN.
